// File: rtl/amo_seq.sv
// Load/store/AMO sequencer onto a single-ported memory bus; owns the LR/SC reservation.
// Optional: define AMO_SEQ_MINMAX_EN to execute amo_min/max/minu/maxu (otherwise illegal).
module amo_seq #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [2:0]      req_size,
  input  logic [DW/8-1:0] req_mask,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic            bus_we,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  output logic [DW/8-1:0] bus_mask,
  input  logic            bus_rsp_valid,
  input  logic [DW-1:0]   bus_rdata
);

  localparam logic [3:0] OpLoad  = 4'd0;
  localparam logic [3:0] OpStore = 4'd1;
  localparam logic [3:0] OpAdd   = 4'd2;
  localparam logic [3:0] OpSwap  = 4'd3;
  localparam logic [3:0] OpLr    = 4'd4;
  localparam logic [3:0] OpSc    = 4'd5;
  localparam logic [3:0] OpXor   = 4'd6;
  localparam logic [3:0] OpOr    = 4'd7;
  localparam logic [3:0] OpAnd   = 4'd8;
`ifdef AMO_SEQ_MINMAX_EN
  localparam logic [3:0] OpMin   = 4'd9;
  localparam logic [3:0] OpMax   = 4'd10;
  localparam logic [3:0] OpMinu  = 4'd11;
  localparam logic [3:0] OpMaxu  = 4'd12;
`endif

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StWrWait, StRsp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [AW-4:0]   dw_q, dw_d;
  logic            lane_q, lane_d;
  logic            word_q, word_d;
  logic [DW-1:0]   operand_q, operand_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DW/8-1:0] bus_mask_q, bus_mask_d;
  logic            resv_valid_q, resv_valid_d;
  logic [AW-4:0]   resv_addr_q, resv_addr_d;

  logic            op_legal, op_atomic, size_ok;
  logic [DW/8-1:0] word_mask;
  logic [31:0]     old_lane;
  logic [DW-1:0]   old_val, opnd, amo_res, wr_val;

  // Request decode
  always_comb begin
    op_legal  = 1'b1;
    op_atomic = 1'b1;
    case (req_op)
      OpLoad, OpStore: op_atomic = 1'b0;
      OpAdd, OpSwap, OpLr, OpSc, OpXor, OpOr, OpAnd: op_atomic = 1'b1;
`ifdef AMO_SEQ_MINMAX_EN
      OpMin, OpMax, OpMinu, OpMaxu: op_atomic = 1'b1;
`endif
      default: begin
        op_legal  = 1'b0;
        op_atomic = 1'b0;
      end
    endcase
    case (req_size)
      3'd2:    size_ok = (req_addr[1:0] == 2'b00);
      3'd3:    size_ok = (req_addr[2:0] == 3'b000);
      default: size_ok = 1'b0;
    endcase
    word_mask = req_addr[2] ? 8'hF0 : 8'h0F;
  end

  // Word ops are computed on sign-extended operands; the low 32 bits are the wrapped result
  // and unsigned ordering of sign-extended words matches 32-bit unsigned ordering.
  always_comb begin
    old_lane = lane_q ? bus_rdata[63:32] : bus_rdata[31:0];
    old_val  = word_q ? {{32{old_lane[31]}}, old_lane} : bus_rdata;
    opnd     = word_q ? {{32{operand_q[31]}}, operand_q[31:0]} : operand_q;
    case (op_q)
      OpAdd:   amo_res = old_val + opnd;
      OpXor:   amo_res = old_val ^ opnd;
      OpOr:    amo_res = old_val | opnd;
      OpAnd:   amo_res = old_val & opnd;
`ifdef AMO_SEQ_MINMAX_EN
      OpMin:   amo_res = ($signed(old_val) < $signed(opnd)) ? old_val : opnd;
      OpMax:   amo_res = ($signed(old_val) > $signed(opnd)) ? old_val : opnd;
      OpMinu:  amo_res = (old_val < opnd) ? old_val : opnd;
      OpMaxu:  amo_res = (old_val > opnd) ? old_val : opnd;
`endif
      default: amo_res = opnd;
    endcase
    wr_val = word_q ? {2{amo_res[31:0]}} : amo_res;
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dw_d         = dw_q;
    lane_d       = lane_q;
    word_d       = word_q;
    operand_d    = operand_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_mask_d   = bus_mask_q;
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d       = req_op;
          dw_d       = req_addr[AW-1:3];
          lane_d     = req_addr[2];
          word_d     = (req_size == 3'd2);
          operand_d  = req_wdata;
          bus_addr_d = {req_addr[AW-1:3], 3'b000};
          rsp_err_d  = 1'b0;
          if (!op_legal || (op_atomic && !size_ok)) begin
            rsp_err_d = 1'b1;
            state_d   = StRsp;
          end else if (req_op == OpSc) begin
            resv_valid_d = 1'b0;
            if (resv_valid_q && (resv_addr_q == req_addr[AW-1:3])) begin
              bus_wdata_d = (req_size == 3'd2) ? {2{req_wdata[31:0]}} : req_wdata;
              bus_mask_d  = (req_size == 3'd2) ? word_mask : 8'hFF;
              rsp_rdata_d = '0;
              state_d     = StWrReq;
            end else begin
              rsp_rdata_d = 64'd1;
              state_d     = StRsp;
            end
          end else if (req_op == OpStore) begin
            bus_wdata_d = req_wdata;
            bus_mask_d  = req_mask;
            state_d     = StWrReq;
          end else begin
            if (req_op == OpLoad)       bus_mask_d = req_mask;
            else if (req_size == 3'd2)  bus_mask_d = word_mask;
            else                        bus_mask_d = 8'hFF;
            state_d = StRdReq;
          end
        end
      end
      StRdReq: if (bus_req_ready) state_d = StRdWait;
      StRdWait: begin
        if (bus_rsp_valid) begin
          rsp_rdata_d = (op_q == OpLoad) ? bus_rdata : old_val;
          if (op_q == OpLoad) begin
            state_d = StRsp;
          end else if (op_q == OpLr) begin
            resv_valid_d = 1'b1;
            resv_addr_d  = dw_q;
            state_d      = StRsp;
          end else begin
            bus_wdata_d = wr_val;
            state_d     = StWrReq;
          end
        end
      end
      StWrReq: begin
        if (bus_req_ready) begin
          // A store or AMO hitting the reserved doubleword breaks the reservation.
          if (resv_valid_q && (resv_addr_q == dw_q)) resv_valid_d = 1'b0;
          state_d = StWrWait;
        end
      end
      StWrWait: if (bus_rsp_valid) state_d = StRsp;
      StRsp:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= '0;
      dw_q         <= '0;
      lane_q       <= 1'b0;
      word_q       <= 1'b0;
      operand_q    <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_mask_q   <= '0;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      dw_q         <= dw_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      operand_q    <= operand_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_mask_q   <= bus_mask_d;
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
    end
  end

  assign req_ready     = (state_q == StIdle);
  assign rsp_valid     = (state_q == StRsp);
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q & rsp_valid;
  assign bus_req_valid = (state_q == StRdReq) || (state_q == StWrReq);
  assign bus_we        = (state_q == StWrReq);
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_mask      = bus_mask_q;

endmodule

// File: tb/tb_amo_seq.sv
// Directed bench for amo_seq: behavioural single-ported memory with optional command stall.
module tb_amo_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [2:0]  req_size = '0;
  logic [7:0]  req_mask = '0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_mask;
  logic        bus_rsp_valid = 1'b0;
  logic [63:0] bus_rdata = '0;

  amo_seq #(.AW(64), .DW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_mask(bus_mask),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: accepts one command per cycle, answers on the following cycle.
  logic [63:0] mem [logic [63:0]];
  int          reads = 0, writes = 0, rsp_cnt = 0, stall_cnt = 0;
  logic        stall_en = 1'b0;
  logic [63:0] last_waddr = '0, last_wdata = '0, last_raddr = '0;
  logic [7:0]  last_wmask = '0, last_rmask = '0;

  assign bus_req_ready = !(stall_en && stall_cnt < 3);

  always @(posedge clk) begin
    logic [63:0] bm, cur;
    bus_rsp_valid <= 1'b0;
    if (!stall_en) stall_cnt <= 0;
    else if (bus_req_valid && stall_cnt < 3) stall_cnt <= stall_cnt + 1;
    if (bus_req_valid && bus_req_ready) begin
      bus_rsp_valid <= 1'b1;
      cur = mem.exists(bus_addr) ? mem[bus_addr] : 64'd0;
      if (bus_we) begin
        for (int b = 0; b < 8; b++) bm[b*8 +: 8] = {8{bus_mask[b]}};
        mem[bus_addr] = (cur & ~bm) | (bus_wdata & bm);
        writes     <= writes + 1;
        last_waddr <= bus_addr;
        last_wdata <= bus_wdata;
        last_wmask <= bus_mask;
      end else begin
        bus_rdata  <= cur;
        reads      <= reads + 1;
        last_raddr <= bus_addr;
        last_rmask <= bus_mask;
      end
    end
  end

  always @(posedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic send_req(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [2:0] size, input logic [7:0] mask);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    req_size = size; req_mask = mask;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Latency counts negedges after the accepting edge up to the rsp_valid sample.
  task automatic wait_rsp(output logic [63:0] rd, output logic err, output int lat);
    bit got = 0;
    rd = '0; err = 1'b0; lat = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin got = 1; rd = rsp_rdata; err = rsp_err; end
    end
    if (!got) check_eq("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_req(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [2:0] size, input logic [7:0] mask,
                        output logic [63:0] rd, output logic err, output int lat);
    send_req(op, addr, wd, size, mask);
    wait_rsp(rd, err, lat);
  endtask

  task automatic poke(input logic [63:0] addr, input logic [63:0] data);
    logic [63:0] rd; logic err; int lat;
    do_req(4'd1, addr, data, 3'd3, 8'hFF, rd, err, lat);
  endtask

  initial begin
    logic [63:0] rd; logic err; int lat, r0, w0, c0;

    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_bus_req_valid", bus_req_valid, 0);
    check_eq("rst_bus_we", bus_we, 0);
    check_eq("rst_bus_addr", bus_addr, 0);
    check_eq("rst_bus_wdata", bus_wdata, 0);
    check_eq("rst_bus_mask", bus_mask, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;

    // Plain store then load: raw data, passthrough mask, zero-wait latency
    poke(64'h5000, 64'h1122_3344_5566_7788);
    do_req(4'd0, 64'h5000, 0, 3'd3, 8'h0F, rd, err, lat);
    check_eq("load_rdata", rd, 64'h1122_3344_5566_7788);
    check_eq("load_rmask", last_rmask, 8'h0F);
    check_eq("load_latency", lat, 3);
    do_req(4'd1, 64'h5000, 64'hDEAD_BEEF_0000_0000, 3'd3, 8'hF0, rd, err, lat);
    check_eq("store_wmask", last_wmask, 8'hF0);
    check_eq("store_latency", lat, 3);
    do_req(4'd0, 64'h5000, 0, 3'd3, 8'hFF, rd, err, lat);
    check_eq("store_merge", rd, 64'hDEAD_BEEF_5566_7788);

    // amo_add.d
    poke(64'h1000, 64'h10);
    r0 = reads; w0 = writes;
    do_req(4'd2, 64'h1000, 64'd5, 3'd3, 8'h00, rd, err, lat);
    check_eq("add_rdata", rd, 64'h10);
    check_eq("add_err", err, 0);
    check_eq("add_reads", reads - r0, 1);
    check_eq("add_writes", writes - w0, 1);
    check_eq("add_raddr", last_raddr, 64'h1000);
    check_eq("add_waddr", last_waddr, 64'h1000);
    check_eq("add_wdata", last_wdata, 64'h15);
    check_eq("add_wmask", last_wmask, 8'hFF);

    // amo_swap.w upper lane
    poke(64'h1000, 64'h8000_0001_1234_5678);
    do_req(4'd3, 64'h1004, 64'h0000_0000_AAAA_BBBB, 3'd2, 8'h00, rd, err, lat);
    check_eq("swapw_rdata", rd, 64'hFFFF_FFFF_8000_0001);
    check_eq("swapw_wmask", last_wmask, 8'hF0);
    check_eq("swapw_wdata_hi", last_wdata[63:32], 32'hAAAA_BBBB);
    check_eq("swapw_mem", mem[64'h1000], 64'hAAAA_BBBB_1234_5678);

    // amo_add.w wraps at 32 bits, lower lane
    poke(64'h6000, 64'h0000_0000_7FFF_FFFF);
    do_req(4'd2, 64'h6000, 64'd1, 3'd2, 8'h00, rd, err, lat);
    check_eq("addw_rdata", rd, 64'h7FFF_FFFF);
    check_eq("addw_wdata_lo", last_wdata[31:0], 32'h8000_0000);
    check_eq("addw_wmask", last_wmask, 8'h0F);

    // LR/SC success, then repeated SC fails without a bus access
    poke(64'h2000, 64'h42);
    do_req(4'd4, 64'h2000, 0, 3'd3, 8'h00, rd, err, lat);
    check_eq("lr_rdata", rd, 64'h42);
    w0 = writes;
    do_req(4'd5, 64'h2000, 64'd7, 3'd3, 8'h00, rd, err, lat);
    check_eq("sc_ok_rdata", rd, 0);
    check_eq("sc_ok_writes", writes - w0, 1);
    check_eq("sc_ok_mem", mem[64'h2000], 64'd7);
    r0 = reads; w0 = writes;
    do_req(4'd5, 64'h2000, 64'd8, 3'd3, 8'h00, rd, err, lat);
    check_eq("sc2_rdata", rd, 1);
    check_eq("sc2_bus", (reads - r0) + (writes - w0), 0);
    check_eq("sc2_latency", lat, 1);

    // Store to reserved doubleword breaks it; store elsewhere does not
    do_req(4'd4, 64'h2000, 0, 3'd3, 8'h00, rd, err, lat);
    poke(64'h2000, 64'd9);
    do_req(4'd5, 64'h2000, 64'd3, 3'd3, 8'h00, rd, err, lat);
    check_eq("sc_after_store", rd, 1);
    do_req(4'd4, 64'h2000, 0, 3'd3, 8'h00, rd, err, lat);
    poke(64'h3000, 64'd11);
    do_req(4'd5, 64'h2000, 64'd3, 3'd3, 8'h00, rd, err, lat);
    check_eq("sc_after_other_store", rd, 0);
    do_req(4'd4, 64'h2000, 0, 3'd3, 8'h00, rd, err, lat);
    do_req(4'd5, 64'h2008, 64'd3, 3'd3, 8'h00, rd, err, lat);
    check_eq("sc_wrong_addr", rd, 1);
    do_req(4'd5, 64'h2000, 64'd3, 3'd3, 8'h00, rd, err, lat);
    check_eq("sc_resv_cleared", rd, 1);

    // Error cases: one cycle, no bus access
    r0 = reads; w0 = writes;
    do_req(4'd2, 64'h1004, 64'd1, 3'd3, 8'h00, rd, err, lat);
    check_eq("misalign_err", err, 1);
    check_eq("misalign_latency", lat, 1);
    do_req(4'd13, 64'h1000, 64'd1, 3'd3, 8'h00, rd, err, lat);
    check_eq("illegal_err", err, 1);
    do_req(4'd2, 64'h1000, 64'd1, 3'd1, 8'h00, rd, err, lat);
    check_eq("badsize_err", err, 1);
    check_eq("err_no_bus", (reads - r0) + (writes - w0), 0);

    // Read command stalled three cycles stays stable
    poke(64'h1000, 64'hAAAA_BBBB_1234_5678);
    r0 = reads; w0 = writes;
    stall_en = 1'b1;
    send_req(4'd6, 64'h1000, 64'hFF, 3'd3, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_valid", {bus_req_valid, bus_req_ready, bus_we}, 3'b100);
      check_eq("stall_addr", bus_addr, 64'h1000);
    end
    wait_rsp(rd, err, lat);
    stall_en = 1'b0;
    check_eq("stall_reads", reads - r0, 1);
    check_eq("stall_writes", writes - w0, 1);
    check_eq("stall_rdata", rd, 64'hAAAA_BBBB_1234_5678);
    check_eq("stall_xor_wdata", last_wdata, 64'hAAAA_BBBB_1234_5687);

    // Optional min/max
    poke(64'h4000, 64'd5);
    r0 = reads; w0 = writes;
    do_req(4'd9, 64'h4000, 64'h0000_0000_FFFF_FFFE, 3'd2, 8'h00, rd, err, lat);
`ifdef AMO_SEQ_MINMAX_EN
    check_eq("minw_err", err, 0);
    check_eq("minw_rdata", rd, 64'd5);
    check_eq("minw_wdata_lo", last_wdata[31:0], 32'hFFFF_FFFE);
    check_eq("minw_wmask", last_wmask, 8'h0F);
`else
    check_eq("minw_err", err, 1);
    check_eq("minw_no_bus", (reads - r0) + (writes - w0), 0);
`endif

    // Reset during WR_WAIT
    do_req(4'd4, 64'h2000, 0, 3'd3, 8'h00, rd, err, lat);
    send_req(4'd1, 64'h3000, 64'h55, 3'd3, 8'hFF);
    @(negedge clk);
    check_eq("wr_req_state", {bus_req_valid, bus_we}, 2'b11);
    @(negedge clk);
    check_eq("wr_wait_state", {bus_req_valid, rsp_valid}, 2'b00);
    c0 = rsp_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req_ready", req_ready, 1);
    check_eq("mid_rst_outputs", {rsp_valid, rsp_err, bus_req_valid, bus_we}, 4'b0000);
    check_eq("mid_rst_bus_addr", bus_addr, 0);
    check_eq("mid_rst_bus_wdata", bus_wdata, 0);
    check_eq("mid_rst_bus_mask", bus_mask, 0);
    check_eq("mid_rst_rsp_rdata", rsp_rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("mid_rst_no_rsp", rsp_cnt - c0, 0);
    w0 = writes;
    do_req(4'd5, 64'h2000, 64'd1, 3'd3, 8'h00, rd, err, lat);
    check_eq("mid_rst_resv_gone", rd, 1);
    check_eq("mid_rst_sc_no_write", writes - w0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
